icache_responder: RTL and testbench

- Direct-mapped instruction cache on the memory side of the 2-wide fetch stage.
- Fetch drives an 8-byte-aligned block address every cycle. This block returns the 64-bit block (two 32-bit instructions) combinationally on a hit.
- On a miss it issues a tagged BUS_LOAD to the shared memory port (arbitrated with the D-cache), waits for the matching tag and fills the line.
- Sits between fetch and the memory arbiter.

---
 rtl/icache_responder_pkg.sv | 28 ++
 rtl/icache_mem.sv | 57 +++++
 rtl/icache_responder.sv | 133 +++++++++++++
 tb/tb_icache_responder.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_responder_pkg.sv
// rtl/icache_responder_pkg.sv - shared bus encodings, cache geometry and line types for the instruction cache
package icache_responder_pkg;

    localparam int ICACHE_XLEN  = 32;
    localparam int ICACHE_LINES = 32;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_LINES);
    localparam int ICACHE_TAG_W = ICACHE_XLEN - 3 - ICACHE_IDX_W;

    typedef enum logic [1:0] {
        BUS_NONE = 2'b00,
        BUS_LOAD = 2'b01
    } bus_command_t;

    typedef logic [ICACHE_TAG_W-1:0] icache_tag_t;

    typedef struct packed {
        logic        valid;
        icache_tag_t tag;
        logic [63:0] data;
    } icache_line_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } icache_state_t;

endpackage

// File: rtl/icache_mem.sv
// rtl/icache_mem.sv - line storage: async read port, sync write port, async clear of valid bits
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low clear of all valid bits
//   rd_idx                read index; rd_valid/rd_tag/rd_data follow it combinationally
//   wr_en/wr_idx/...      on a rising edge with wr_en, the line at wr_idx becomes
//                         valid with wr_tag/wr_data
module icache_mem #(
    parameter int NUM_LINES = 32,
    parameter int IDX_W     = $clog2(NUM_LINES),
    parameter int TAG_W     = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [63:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [63:0]      wr_data
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] valid_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [63:0]          data_q [NUM_LINES];

    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data need no reset: they are only trusted behind a set valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache_responder.sv
// rtl/icache_responder.sv - direct-mapped instruction cache with single outstanding tagged miss
//
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   proc2Icache_addr                fetch block address, bits [2:0] ignored
//   Icache2proc_data/valid          64-bit block {inst@addr+4, inst@addr}, combinational
//   proc2Imem_command/addr          BUS_LOAD request for the missing block
//   mem_grant_i, Imem2proc_response arbiter grant and accepted transaction tag
//   Imem2proc_data/tag              returned block and its tag (0 = nothing)
module icache_responder
    import icache_responder_pkg::*;
#(
    parameter int XLEN      = ICACHE_XLEN,
    parameter int NUM_LINES = ICACHE_LINES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] proc2Icache_addr,
    output logic [63:0]     Icache2proc_data,
    output logic            Icache2proc_valid,
    output logic [1:0]      proc2Imem_command,
    output logic [XLEN-1:0] proc2Imem_addr,
    input  logic            mem_grant_i,
    input  logic [3:0]      Imem2proc_response,
    input  logic [63:0]     Imem2proc_data,
    input  logic [3:0]      Imem2proc_tag
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = XLEN - 3 - IDX_W;
    localparam int BLK_W = XLEN - 3;

    icache_state_t    state_q, state_d;
    logic [BLK_W-1:0] miss_blk_q, miss_blk_d;
    logic [3:0]       miss_tag_q, miss_tag_d;

    logic [BLK_W-1:0] fetch_blk;
    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic             unused_addr_bits;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [63:0]      rd_data;
    logic             hit;
    logic             fill_en;

    // Byte offset within the 8-byte block is irrelevant to fetch.
    assign unused_addr_bits = ^proc2Icache_addr[2:0];
    assign fetch_blk        = proc2Icache_addr[XLEN-1:3];
    assign fetch_idx        = fetch_blk[IDX_W-1:0];
    assign fetch_tag        = fetch_blk[BLK_W-1:IDX_W];
    assign hit              = rd_valid && (rd_tag == fetch_tag);

    icache_mem #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_mem (
        .clk      (clk),
        .rst_n    (reset),
        .rd_idx   (fetch_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill_en),
        .wr_idx   (miss_blk_q[IDX_W-1:0]),
        .wr_tag   (miss_blk_q[BLK_W-1:IDX_W]),
        .wr_data  (Imem2proc_data)
    );

    always_comb begin
        state_d           = state_q;
        miss_blk_d        = miss_blk_q;
        miss_tag_d        = miss_tag_q;
        fill_en           = 1'b0;
        Icache2proc_valid = hit;
        Icache2proc_data  = hit ? rd_data : 64'd0;
        proc2Imem_command = BUS_NONE;
        proc2Imem_addr    = '0;

        case (state_q)
            ST_IDLE: begin
                if (!hit) begin
                    state_d    = ST_REQ;
                    miss_blk_d = fetch_blk;
                end
            end
            ST_REQ: begin
                proc2Imem_command = BUS_LOAD;
                proc2Imem_addr    = {miss_blk_q, 3'b000};
                if (mem_grant_i && (Imem2proc_response != 4'd0)) begin
                    miss_tag_d = Imem2proc_response;
                    state_d    = ST_WAIT;
                end else if (fetch_blk != miss_blk_q) begin
                    // Request not yet accepted, so it can be dropped or redirected freely.
                    if (hit) begin
                        state_d = ST_IDLE;
                    end else begin
                        miss_blk_d = fetch_blk;
                    end
                end
            end
            ST_WAIT: begin
                if ((Imem2proc_tag == miss_tag_q) && (miss_tag_q != 4'd0)) begin
                    fill_en = 1'b1;
                    state_d = ST_IDLE;
                    // Forward the returning block so fetch need not wait for the write.
                    if (fetch_blk == miss_blk_q) begin
                        Icache2proc_valid = 1'b1;
                        Icache2proc_data  = Imem2proc_data;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            miss_blk_q <= '0;
            miss_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            miss_blk_q <= miss_blk_d;
            miss_tag_q <= miss_tag_d;
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// tb/tb_icache_responder.sv - self-checking bench for icache_responder
module tb_icache_responder;
    import icache_responder_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] proc2Icache_addr;
    logic [63:0] Icache2proc_data;
    logic        Icache2proc_valid;
    logic [1:0]  proc2Imem_command;
    logic [31:0] proc2Imem_addr;
    logic        mem_grant_i;
    logic [3:0]  Imem2proc_response;
    logic [63:0] Imem2proc_data;
    logic [3:0]  Imem2proc_tag;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: line contents by index, plus the one transaction in flight.
    bit          m_ok  [32];
    int unsigned m_blk [32];
    bit          p_req;
    bit          p_wait;
    int unsigned p_blk;
    int unsigned p_tag;
    int unsigned p_cnt;

    icache_responder dut (
        .clk                (clk),
        .reset              (reset),
        .proc2Icache_addr   (proc2Icache_addr),
        .Icache2proc_data   (Icache2proc_data),
        .Icache2proc_valid  (Icache2proc_valid),
        .proc2Imem_command  (proc2Imem_command),
        .proc2Imem_addr     (proc2Imem_addr),
        .mem_grant_i        (mem_grant_i),
        .Imem2proc_response (Imem2proc_response),
        .Imem2proc_data     (Imem2proc_data),
        .Imem2proc_tag      (Imem2proc_tag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory image: each block holds its own two word addresses.
    function automatic logic [63:0] mem_blk(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:3], 3'b000};
        return {b + 32'd4, b};
    endfunction

    function automatic logic [98:0] obs();
        return {Icache2proc_valid, Icache2proc_data, proc2Imem_command, proc2Imem_addr};
    endfunction

    function automatic logic [98:0] ex(input logic v, input logic [63:0] d,
                                       input logic [1:0] c, input logic [31:0] a);
        return {v, d, c, a};
    endfunction

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_grant_i        = 1'b0;
        Imem2proc_response = 4'd0;
        Imem2proc_data     = 64'd0;
        Imem2proc_tag      = 4'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Complete a miss on addr with zero grant wait and two cycles of memory latency.
    task automatic fill(input logic [31:0] addr, input logic [3:0] t);
        proc2Icache_addr = addr;
        mem_grant_i = 1'b1; Imem2proc_response = 4'd0; Imem2proc_tag = 4'd0;
        go();
        Imem2proc_response = t;
        go();
        Imem2proc_response = 4'd0;
        go();
        go();
        Imem2proc_tag = t; Imem2proc_data = mem_blk(addr);
        go();
        Imem2proc_tag = 4'd0; Imem2proc_data = 64'd0;
    endtask

    task automatic test_reset();
        logic [98:0] e;
        reset = 1'b1;
        proc2Icache_addr = 32'h0;
        idle_inputs();
        #2 reset = 1'b0;
        #1;
        e = ex(1'b0, 64'd0, BUS_NONE, 32'h0);
        if (obs() !== e) begin n_fail++; $display("FAIL reset_async: got %h expected %h", obs(), e); end
        n_checks++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (obs() !== e) begin n_fail++; $display("FAIL reset_held: got %h expected %h", obs(), e); end
        n_checks++;
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_cold_miss();
        logic [98:0] e;
        do_reset();
        proc2Icache_addr = 32'h0; mem_grant_i = 1'b1;
        @(negedge clk);
        e = ex(1'b0, 64'd0, BUS_NONE, 32'h0);
        if (obs() !== e) begin n_fail++; $display("FAIL cold_idle: got %h expected %h", obs(), e); end
        n_checks++;
        go();
        Imem2proc_response = 4'd1;
        @(negedge clk);
        e = ex(1'b0, 64'd0, BUS_LOAD, 32'h0);
        if (obs() !== e) begin n_fail++; $display("FAIL cold_req: got %h expected %h", obs(), e); end
        n_checks++;
        go();
        Imem2proc_response = 4'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            e = ex(1'b0, 64'd0, BUS_NONE, 32'h0);
            if (obs() !== e) begin n_fail++; $display("FAIL cold_wait%0d: got %h expected %h", i, obs(), e); end
            n_checks++;
            go();
        end
        Imem2proc_tag = 4'd1; Imem2proc_data = {32'd4, 32'd0};
        @(negedge clk);
        e = ex(1'b1, {32'd4, 32'd0}, BUS_NONE, 32'h0);
        if (obs() !== e) begin n_fail++; $display("FAIL cold_forward: got %h expected %h", obs(), e); end
        n_checks++;
        go();
        Imem2proc_tag = 4'd0; Imem2proc_data = 64'd0;
        @(negedge clk);
        if (obs() !== e) begin n_fail++; $display("FAIL cold_hit_after: got %h expected %h", obs(), e); end
        n_checks++;
    endtask

    task automatic test_hits();
        logic [98:0] e;
        logic [31:0] a;
        do_reset();
        fill(32'h8, 4'd1);
        fill(32'h10, 4'd2);
        for (int i = 0; i < 8; i++) begin
            a = ((i % 2) == 1) ? 32'h10 : 32'h8;
            proc2Icache_addr = a | 32'($urandom_range(0, 7));
            @(negedge clk);
            e = ex(1'b1, mem_blk(a), BUS_NONE, 32'h0);
            if (obs() !== e) begin n_fail++; $display("FAIL hit_alt%0d: got %h expected %h", i, obs(), e); end
            n_checks++;
            go();
        end
    endtask

    task automatic test_grant_denied();
        logic [98:0] e;
        do_reset();
        proc2Icache_addr = 32'h18; mem_grant_i = 1'b0; Imem2proc_response = 4'd2;
        go();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            e = ex(1'b0, 64'd0, BUS_LOAD, 32'h18);
            if (obs() !== e) begin n_fail++; $display("FAIL denied%0d: got %h expected %h", i, obs(), e); end
            n_checks++;
            go();
        end
        mem_grant_i = 1'b1;
        @(negedge clk);
        if (obs() !== e) begin n_fail++; $display("FAIL denied_grant: got %h expected %h", obs(), e); end
        n_checks++;
        go();
        mem_grant_i = 1'b0; Imem2proc_response = 4'd0;
        @(negedge clk);
        e = ex(1'b0, 64'd0, BUS_NONE, 32'h0);
        if (obs() !== e) begin n_fail++; $display("FAIL denied_wait: got %h expected %h", obs(), e); end
        n_checks++;
        go();
        Imem2proc_tag = 4'd2; Imem2proc_data = mem_blk(32'h18);
        @(negedge clk);
        e = ex(1'b1, mem_blk(32'h18), BUS_NONE, 32'h0);
        if (obs() !== e) begin n_fail++; $display("FAIL denied_forward: got %h expected %h", obs(), e); end
        n_checks++;
        go();
        Imem2proc_tag = 4'd0;
    endtask

    task automatic test_retarget();
        logic [98:0] e;
        do_reset();
        proc2Icache_addr = 32'h20; mem_grant_i = 1'b1; Imem2proc_response = 4'd0;
        go();
        @(negedge clk);
        e = ex(1'b0, 64'd0, BUS_LOAD, 32'h20);
        if (obs() !== e) begin n_fail++; $display("FAIL retarget_first: got %h expected %h", obs(), e); end
        n_checks++;
        go();
        proc2Icache_addr = 32'h28;
        go();
        @(negedge clk);
        e = ex(1'b0, 64'd0, BUS_LOAD, 32'h28);
        if (obs() !== e) begin n_fail++; $display("FAIL retarget_new: got %h expected %h", obs(), e); end
        n_checks++;
        go();
        Imem2proc_response = 4'd3;
        go();
        Imem2proc_response = 4'd0; Imem2proc_tag = 4'd3; Imem2proc_data = mem_blk(32'h28);
        @(negedge clk);
        e = ex(1'b1, mem_blk(32'h28), BUS_NONE, 32'h0);
        if (obs() !== e) begin n_fail++; $display("FAIL retarget_fill: got %h expected %h", obs(), e); end
        n_checks++;
        go();
        Imem2proc_tag = 4'd0; proc2Icache_addr = 32'h20;
        @(negedge clk);
        e = ex(1'b0, 64'd0, BUS_NONE, 32'h0);
        if (obs() !== e) begin n_fail++; $display("FAIL retarget_old_unfilled: got %h expected %h", obs(), e); end
        n_checks++;
    endtask

    task automatic test_eviction();
        logic [98:0] e;
        do_reset();
        fill(32'h0, 4'd5);
        @(negedge clk);
        e = ex(1'b1, mem_blk(32'h0), BUS_NONE, 32'h0);
        if (obs() !== e) begin n_fail++; $display("FAIL evict_first_hit: got %h expected %h", obs(), e); end
        n_checks++;
        fill(32'h100, 4'd6);
        @(negedge clk);
        e = ex(1'b1, mem_blk(32'h100), BUS_NONE, 32'h0);
        if (obs() !== e) begin n_fail++; $display("FAIL evict_new_hit: got %h expected %h", obs(), e); end
        n_checks++;
        go();
        proc2Icache_addr = 32'h0;
        @(negedge clk);
        e = ex(1'b0, 64'd0, BUS_NONE, 32'h0);
        if (obs() !== e) begin n_fail++; $display("FAIL evict_old_miss: got %h expected %h", obs(), e); end
        n_checks++;
        go();
        @(negedge clk);
        e = ex(1'b0, 64'd0, BUS_LOAD, 32'h0);
        if (obs() !== e) begin n_fail++; $display("FAIL evict_reload: got %h expected %h", obs(), e); end
        n_checks++;
    endtask

    task automatic test_reset_mid_miss();
        logic [98:0] e;
        do_reset();
        fill(32'h8, 4'd7);
        proc2Icache_addr = 32'h0; mem_grant_i = 1'b1;
        go();
        Imem2proc_response = 4'd4;
        go();
        Imem2proc_response = 4'd0; proc2Icache_addr = 32'h8;
        @(negedge clk);
        e = ex(1'b1, mem_blk(32'h8), BUS_NONE, 32'h0);
        if (obs() !== e) begin n_fail++; $display("FAIL midrst_hit_in_wait: got %h expected %h", obs(), e); end
        n_checks++;
        #1 reset = 1'b0;
        #1;
        e = ex(1'b0, 64'd0, BUS_NONE, 32'h0);
        if (obs() !== e) begin n_fail++; $display("FAIL midrst_immediate: got %h expected %h", obs(), e); end
        n_checks++;
        go();
        reset = 1'b1;
        proc2Icache_addr = 32'h0; Imem2proc_tag = 4'd4; Imem2proc_data = mem_blk(32'h0);
        @(negedge clk);
        if (obs() !== e) begin n_fail++; $display("FAIL midrst_late_tag: got %h expected %h", obs(), e); end
        n_checks++;
        go();
        Imem2proc_tag = 4'd0; Imem2proc_data = 64'd0;
        @(negedge clk);
        e = ex(1'b0, 64'd0, BUS_LOAD, 32'h0);
        if (obs() !== e) begin n_fail++; $display("FAIL midrst_remiss: got %h expected %h", obs(), e); end
        n_checks++;
        go();
        proc2Icache_addr = 32'h8;
        @(negedge clk);
        if (obs() !== e) begin n_fail++; $display("FAIL midrst_valid_cleared: got %h expected %h", obs(), e); end
        n_checks++;
    endtask

    task automatic test_random();
        logic [98:0] e;
        int unsigned blk, idx, b;
        bit hit, ret;
        do_reset();
        for (int i = 0; i < 32; i++) begin m_ok[i] = 1'b0; m_blk[i] = 0; end
        p_req = 1'b0; p_wait = 1'b0; p_blk = 0; p_tag = 0; p_cnt = 0;
        for (int n = 0; n < 800; n++) begin
            if (n == 0 || $urandom_range(0, 2) == 0) begin
                b = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : 32 + $urandom_range(0, 3);
                proc2Icache_addr = (b << 3) | $urandom_range(0, 7);
            end
            mem_grant_i = 1'($urandom_range(0, 1));
            Imem2proc_response = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            if (p_wait && p_cnt == 0) begin
                Imem2proc_tag  = 4'(p_tag);
                Imem2proc_data = mem_blk(p_blk << 3);
            end else if ($urandom_range(0, 3) == 0) begin
                Imem2proc_tag  = 4'((p_tag % 15) + 1);
                Imem2proc_data = {$urandom, $urandom};
            end else begin
                Imem2proc_tag  = 4'd0;
                Imem2proc_data = {$urandom, $urandom};
            end
            blk = proc2Icache_addr >> 3;
            idx = blk % 32;
            hit = m_ok[idx] && (m_blk[idx] == blk);
            ret = p_wait && (32'(Imem2proc_tag) == p_tag);
            if (ret && blk == p_blk)
                e = ex(1'b1, mem_blk(p_blk << 3), BUS_NONE, 32'h0);
            else if (hit)
                e = ex(1'b1, mem_blk(blk << 3), p_req ? BUS_LOAD : BUS_NONE, p_req ? (p_blk << 3) : 32'h0);
            else
                e = ex(1'b0, 64'd0, p_req ? BUS_LOAD : BUS_NONE, p_req ? (p_blk << 3) : 32'h0);
            @(negedge clk);
            if (obs() !== e) begin n_fail++; $display("FAIL random_cycle%0d: got %h expected %h", n, obs(), e); end
            n_checks++;
            if (p_req) begin
                if (mem_grant_i && Imem2proc_response != 4'd0) begin
                    p_req = 1'b0; p_wait = 1'b1;
                    p_tag = 32'(Imem2proc_response);
                    p_cnt = $urandom_range(0, 4);
                end else if (blk != p_blk) begin
                    if (hit) p_req = 1'b0;
                    else     p_blk = blk;
                end
            end else if (p_wait) begin
                if (ret) begin
                    m_ok[p_blk % 32] = 1'b1; m_blk[p_blk % 32] = p_blk; p_wait = 1'b0;
                end else if (p_cnt > 0) begin
                    p_cnt--;
                end
            end else if (!hit) begin
                p_req = 1'b1; p_blk = blk;
            end
            go();
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hits();
        test_grant_denied();
        test_retarget();
        test_eviction();
        test_reset_mid_miss();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
